// File: rtl/tinynpu_pkg.sv
// Shared TinyNPU types and constants: arbiter FSM states and requester count.
package tinynpu_pkg;

    // Arbiter FSM: free round-robin arbitration or a locked burst.
    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    // Unified Buffer requesters: 0 host/control, 1 operand fetch, 2 result writeback.
    localparam int UB_NUM_REQ = 3;

    // Index width that stays legal (>= 1 bit) for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ub_arbiter_if.sv
// Requester-side and Unified-Buffer-side signals of the UB arbiter.
// req_lock exists only when UB_ARB_BURST_EN is defined.
`ifndef TINYNPU_DEFINES_SV
`include "defines.sv"
`endif

interface ub_arbiter_if #(
    parameter int NUM_REQ = tinynpu_pkg::UB_NUM_REQ
);
    logic [NUM_REQ-1:0]                    req;
    logic [NUM_REQ-1:0]                    req_wr_en;
    logic [NUM_REQ-1:0][`ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_REQ-1:0][`BUFFER_WIDTH-1:0] req_wdata;
`ifdef UB_ARB_BURST_EN
    logic [NUM_REQ-1:0]                    req_lock;
`endif
    logic [NUM_REQ-1:0]                    gnt;
    logic [NUM_REQ-1:0]                    rvalid;
    logic [`BUFFER_WIDTH-1:0]              rdata;
    logic                                  ub_wr_en;
    logic [`ADDR_WIDTH-1:0]                ub_addr;
    logic [`BUFFER_WIDTH-1:0]              ub_wdata;
    logic [`BUFFER_WIDTH-1:0]              ub_rdata;

    // Arbiter view: consumes requests and UB read data, drives grants and the UB port.
    modport slave (
`ifdef UB_ARB_BURST_EN
        input  req_lock,
`endif
        input  req, req_wr_en, req_addr, req_wdata, ub_rdata,
        output gnt, rvalid, rdata, ub_wr_en, ub_addr, ub_wdata
    );

    // Requester/memory view: the opposite direction of every signal.
    modport master (
`ifdef UB_ARB_BURST_EN
        output req_lock,
`endif
        output req, req_wr_en, req_addr, req_wdata, ub_rdata,
        input  gnt, rvalid, rdata, ub_wr_en, ub_addr, ub_wdata
    );

endinterface

// File: rtl/defines.sv
// Global width macros shared by the TinyNPU Unified Buffer blocks.
`ifndef TINYNPU_DEFINES_SV
`define TINYNPU_DEFINES_SV

`define ADDR_WIDTH   8
`define BUFFER_WIDTH 32

`endif

// File: rtl/rr_picker.sv
// Combinational rotate-priority encoder: first asserted req at or after start wins.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   start,
    output logic [NUM_REQ-1:0] gnt_oh,
    output logic [IDX_W-1:0]   gnt_idx
);
    localparam int IW1 = IDX_W + 1;
    localparam logic [IDX_W:0] N_EXT = IW1'(NUM_REQ);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]     offset;
    logic [IDX_W:0]       idx_sum;

    // Doubling the vector lets a plain slice implement the rotation.
    assign req_dbl = {req, req};

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
        assign req_rot[gi] = req_dbl[32'(start) + gi];
    end

    // Lowest set bit of the rotated vector, mapped back to a requester index.
    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                offset = IDX_W'(k);
            end
        end
        idx_sum = {1'b0, start} + {1'b0, offset};
        if (idx_sum >= N_EXT) begin
            idx_sum = idx_sum - N_EXT;
        end
        gnt_idx = idx_sum[IDX_W-1:0];
        gnt_oh  = (|req_rot) ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/ub_arbiter.sv
// Unified Buffer arbiter: round-robin single-cycle grant, combinational UB port
// mux, registered per-requester read-valid one cycle after a granted read.
// Optional locked bursts are compiled in with UB_ARB_BURST_EN.
`ifndef TINYNPU_DEFINES_SV
`include "defines.sv"
`endif

module ub_arbiter
    import tinynpu_pkg::*;
#(
    parameter int NUM_REQ   = UB_NUM_REQ,
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    ub_arbiter_if.slave bus
);
    localparam int IDX_W = idx_width(NUM_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [IDX_W-1:0]   last_gnt_q, last_gnt_d;
    logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
    logic [IDX_W-1:0]   start_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] pick_oh;
    logic [NUM_REQ-1:0] gnt_raw;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;

    // Search starts just past the last winner; after a burst this also
    // pushes the burst owner to the lowest priority.
    assign start_idx = (last_gnt_q == LAST_IDX) ? '0 : last_gnt_q + IDX_W'(1);

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req     (bus.req),
        .start   (start_idx),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx)
    );

`ifdef UB_ARB_BURST_EN
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    arb_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    // Burst FSM: the owner (last winner) keeps the grant until it releases
    // req/req_lock or hits MAX_BURST beats.
    always_comb begin
        gnt_raw    = pick_oh;
        gnt_idx    = pick_idx;
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        if (state_q == BURST) begin
            gnt_raw = '0;
            gnt_idx = last_gnt_q;
            if (bus.req[last_gnt_q]) begin
                gnt_raw[last_gnt_q] = 1'b1;
                beat_cnt_d          = beat_cnt_q + BEAT_W'(1);
                if (!bus.req_lock[last_gnt_q] || beat_cnt_q == LAST_BEAT) begin
                    state_d    = ARB;
                    beat_cnt_d = '0;
                end
            end else begin
                state_d    = ARB;
                beat_cnt_d = '0;
            end
        end else if ((|pick_oh) && bus.req_lock[pick_idx] && (MAX_BURST > 1)) begin
            state_d    = BURST;
            beat_cnt_d = BEAT_W'(1);
        end
    end
`else
    assign gnt_raw = pick_oh;
    assign gnt_idx = pick_idx;

    // MAX_BURST has no effect when bursts are compiled out.
    if (MAX_BURST < 1) begin : g_max_burst_unused
    end
`endif

    // Reset silences the combinational grant path immediately.
    assign gnt     = rst ? '0 : gnt_raw;
    assign gnt_any = |gnt;

    // UB port mux and next values of the pointer and read-valid.
    always_comb begin
        last_gnt_d   = gnt_any ? gnt_idx : last_gnt_q;
        rvalid_d     = gnt & ~bus.req_wr_en;
        bus.gnt      = gnt;
        bus.ub_wr_en = 1'b0;
        bus.ub_addr  = '0;
        bus.ub_wdata = '0;
        if (gnt_any) begin
            bus.ub_wr_en = bus.req_wr_en[gnt_idx];
            bus.ub_addr  = bus.req_addr[gnt_idx];
            bus.ub_wdata = bus.req_wdata[gnt_idx];
        end
    end

    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = (|rvalid_q) ? bus.ub_rdata : '0;

    // Pointer, read-valid and burst state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= LAST_IDX;
            rvalid_q   <= '0;
`ifdef UB_ARB_BURST_EN
            state_q    <= ARB;
            beat_cnt_q <= '0;
`endif
        end else begin
            last_gnt_q <= last_gnt_d;
            rvalid_q   <= rvalid_d;
`ifdef UB_ARB_BURST_EN
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ub_arbiter.sv
// Scoreboard bench for ub_arbiter: directed scenarios then random traffic,
// checked against a rule-level reference model.
`ifndef TINYNPU_DEFINES_SV
`include "defines.sv"
`endif

module tb_ub_arbiter;
    localparam int NR = 3;
    localparam int MB = 16;
    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `BUFFER_WIDTH;
`ifdef UB_ARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    typedef struct {
        logic [NR-1:0] gnt;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } exp_t;

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rd_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    exp_t exp_q[$];
    rd_t  rd_q[$];

    // Reference model state
    int            m_last;
    bit            m_burst;
    int            m_beats;
    logic [DW-1:0] ref_mem [int];

    // UB memory model
    logic [DW-1:0] ub_mem  [0:(1<<AW)-1];
    bit            ub_seen [0:(1<<AW)-1];

    ub_arbiter_if #(.NUM_REQ(NR)) bus();

    ub_arbiter #(
        .NUM_REQ   (NR),
        .MAX_BURST (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return DW'(32'h9E37_79B9 * (32'(a) + 32'd1));
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_val(a);
    endfunction

    // Unified Buffer: write on the edge, synchronous read with 1-cycle latency
    always @(posedge clk) begin
        if (bus.ub_wr_en) begin
            ub_mem[bus.ub_addr]  <= bus.ub_wdata;
            ub_seen[bus.ub_addr] <= 1'b1;
        end
        bus.ub_rdata <= ub_seen[bus.ub_addr] ? ub_mem[bus.ub_addr] : init_val(bus.ub_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
        total++;
        if (act !== req_v) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, req_v);
        end
    endtask

    // Apply one cycle of stimulus and push the reference model's expectations
    task automatic step(input logic r, input logic [NR-1:0] rq, input logic [NR-1:0] wr,
                        input logic [NR-1:0] lk, input logic [NR-1:0][AW-1:0] ad,
                        input logic [NR-1:0][DW-1:0] wd);
        exp_t e;
        rd_t  rr;
        int   win;
        int   cand;
        @(posedge clk);
        #1;
        cyc++;
        rst           = r;
        bus.req       = rq;
        bus.req_wr_en = wr;
        bus.req_addr  = ad;
        bus.req_wdata = wd;
`ifdef UB_ARB_BURST_EN
        bus.req_lock  = lk;
`endif
        e = '{gnt: '0, wr: 1'b0, addr: '0, wdata: '0};
        if (r) begin
            m_last  = NR - 1;
            m_burst = 1'b0;
            m_beats = 0;
            rd_q.delete();
        end else begin
            win = -1;
            if (m_burst) begin
                if (rq[m_last]) begin
                    win = m_last;
                    m_beats++;
                    if (!lk[m_last] || m_beats == MB) m_burst = 1'b0;
                end else begin
                    m_burst = 1'b0;
                end
            end else begin
                for (int k = 1; k <= NR; k++) begin
                    cand = (m_last + k) % NR;
                    if (win < 0 && rq[cand]) win = cand;
                end
                if (win >= 0 && BURST_ON && lk[win] && MB > 1) begin
                    m_burst = 1'b1;
                    m_beats = 1;
                end
            end
            if (win >= 0) begin
                e.gnt[win] = 1'b1;
                e.wr       = wr[win];
                e.addr     = ad[win];
                e.wdata    = wd[win];
                m_last     = win;
                if (wr[win]) begin
                    ref_mem[int'(ad[win])] = wd[win];
                end else begin
                    rr = '{due: cyc + 1, idx: win, data: ref_read(ad[win])};
                    rd_q.push_back(rr);
                end
            end
        end
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs with the queued expectations each cycle
    initial begin : monitor
        exp_t          e;
        rd_t           rr;
        logic [NR-1:0] exp_rv;
        logic [DW-1:0] exp_rd;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            chk("gnt",      64'(bus.gnt),      64'(e.gnt));
            chk("ub_wr_en", 64'(bus.ub_wr_en), 64'(e.wr));
            chk("ub_addr",  64'(bus.ub_addr),  64'(e.addr));
            chk("ub_wdata", 64'(bus.ub_wdata), 64'(e.wdata));
            exp_rv = '0;
            exp_rd = '0;
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                rr = rd_q.pop_front();
                exp_rv[rr.idx] = 1'b1;
                exp_rd = rr.data;
            end
            chk("rvalid", 64'(bus.rvalid), 64'(exp_rv));
            chk("rdata",  64'(bus.rdata),  64'(exp_rd));
            if ((|bus.gnt) || (|bus.rvalid))
                $display("txn cyc=%0d rst=%b gnt=%b wr=%b addr=%h wdata=%h rvalid=%b rdata=%h",
                         cyc, rst, bus.gnt, bus.ub_wr_en, bus.ub_addr, bus.ub_wdata,
                         bus.rvalid, bus.rdata);
        end
    end

    // Driver: directed scenarios followed by random traffic
    initial begin : driver
        logic [NR-1:0][AW-1:0] ad;
        logic [NR-1:0][DW-1:0] wd;
        logic [NR-1:0]         rq, wr, lk;
        logic                  r;
        rst           = 1'b1;
        bus.req       = '0;
        bus.req_wr_en = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
`ifdef UB_ARB_BURST_EN
        bus.req_lock  = '0;
`endif
        m_last  = NR - 1;
        m_burst = 1'b0;
        m_beats = 0;
        ad = '0;
        wd = '0;

        // Requests during reset must stay ungranted
        repeat (3) step(1'b1, 3'b111, 3'b000, 3'b000, ad, wd);
        // Full rotation from requester 0
        repeat (6) step(1'b0, 3'b111, 3'b000, 3'b000, ad, wd);
        // Requester 1 stores DEADBEEF at 0x05, then reads it back
        ad[1] = 8'h05;
        wd[1] = 32'hDEAD_BEEF;
        step(1'b0, 3'b010, 3'b010, 3'b000, ad, wd);
        step(1'b0, 3'b010, 3'b000, 3'b000, ad, wd);
        step(1'b0, 3'b000, 3'b000, 3'b000, ad, wd);
        // Write from 0 and read from 2 of the same address, 0 wins first
        step(1'b1, 3'b000, 3'b000, 3'b000, ad, wd);
        ad[0] = 8'h0A;
        ad[2] = 8'h0A;
        wd[0] = 32'h0BAD_F00D;
        step(1'b0, 3'b101, 3'b001, 3'b000, ad, wd);
        step(1'b0, 3'b100, 3'b000, 3'b000, ad, wd);
        step(1'b0, 3'b000, 3'b000, 3'b000, ad, wd);
        // Reset right after a granted read kills its rvalid
        step(1'b0, 3'b010, 3'b000, 3'b000, ad, wd);
        step(1'b1, 3'b000, 3'b000, 3'b000, ad, wd);
        step(1'b0, 3'b111, 3'b000, 3'b000, ad, wd);
        step(1'b0, 3'b000, 3'b000, 3'b000, ad, wd);
`ifdef UB_ARB_BURST_EN
        // Requester 1 locks with everyone requesting: MAX_BURST beats, then excluded
        step(1'b1, 3'b000, 3'b000, 3'b000, ad, wd);
        step(1'b0, 3'b001, 3'b000, 3'b000, ad, wd);
        repeat (22) step(1'b0, 3'b111, 3'b000, 3'b010, ad, wd);
        step(1'b0, 3'b000, 3'b000, 3'b000, ad, wd);
`endif
        // Random traffic on a small address window to force read-after-write hits
        for (int n = 0; n < 600; n++) begin
            r  = ($urandom_range(0, 49) == 0);
            rq = NR'($urandom);
            wr = NR'($urandom);
            lk = NR'($urandom | $urandom);
            for (int i = 0; i < NR; i++) begin
                ad[i] = AW'($urandom_range(0, 15));
                wd[i] = DW'($urandom);
            end
            step(r, rq, wr, lk, ad, wd);
        end
        step(1'b0, 3'b000, 3'b000, 3'b000, ad, wd);
        step(1'b0, 3'b000, 3'b000, 3'b000, ad, wd);
        @(negedge clk);
        #2;
        chk("drain_exp", 64'(exp_q.size()), 64'd0);
        chk("drain_rd",  64'(rd_q.size()),  64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
